// File: rtl/axi_bus_pkg.sv
// Shared types and helpers for the N-master to 1-slave AXI bus arbiter.
package axi_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    typedef enum int {
        ARB_RR    = 0,
        ARB_FIXED = 1
    } arb_mode_e;

    // Next index after idx in a ring of n entries.
    function automatic int wrapInc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester at or after the
// pointer wins, searching upward and wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Serialises whole single-beat AXI transactions from N masters onto one
// slave port, with round-robin or fixed lowest-index-first arbitration.
module axi_bus_arbiter
    import axi_bus_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ARB_MODE       = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_MASTERS-1:0][AXI_ADDR_WIDTH-1:0]  m_addr,
    input  logic [N_MASTERS-1:0]                      m_avalid,
    input  logic [N_MASTERS-1:0]                      m_awrite,
    input  logic [N_MASTERS-1:0]                      m_wvalid,
    input  logic [N_MASTERS-1:0]                      m_rready,
    input  logic [N_MASTERS-1:0][AXI_DATA_WIDTH-1:0]  m_wdata,
    output logic [N_MASTERS-1:0]                      m_aready,
    output logic [N_MASTERS-1:0]                      m_wready,
    output logic [N_MASTERS-1:0]                      m_rvalid,
    output logic [AXI_DATA_WIDTH-1:0]                 m_rdata,
    output logic [AXI_ADDR_WIDTH-1:0]                 s_addr,
    output logic                                      s_avalid,
    output logic                                      s_awrite,
    output logic                                      s_wvalid,
    output logic                                      s_rready,
    output logic [AXI_DATA_WIDTH-1:0]                 s_wdata,
    input  logic                                      s_aready,
    input  logic                                      s_wready,
    input  logic                                      s_rvalid,
    input  logic [AXI_DATA_WIDTH-1:0]                 s_rdata,
    output logic [$clog2(N_MASTERS)-1:0]              grant_idx,
    output logic                                      busy
);

    localparam int IW         = $clog2(N_MASTERS);
    localparam bit FIXED_MODE = (ARB_MODE == int'(ARB_FIXED));

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic [IW-1:0]        r_ptr;
    logic [IW-1:0]        r_grant;
    logic [N_MASTERS-1:0] r_ownerMask;
    logic [IW-1:0]        w_ptrEff;
    logic [IW-1:0]        w_pickIdx;
    logic [N_MASTERS-1:0] w_pickOneHot;
    logic                 w_any;

    // Fixed priority is the rotating picker with its pointer pinned at 0.
    assign w_ptrEff = FIXED_MODE ? '0 : r_ptr;

    rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .i_req   (m_avalid),
        .i_ptr   (w_ptrEff),
        .o_grant (w_pickOneHot),
        .o_idx   (w_pickIdx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_ownerMask <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_grant     <= w_pickIdx;
                r_ownerMask <= w_pickOneHot;
                if (!FIXED_MODE) begin
                    r_ptr <= IW'(wrapInc(int'(w_pickIdx), N_MASTERS));
                end
            end
        end
    end

    // The owner mask gates every slave-to-master ready/valid so non-owners
    // always see zero, with no added latency.
    always_comb begin
        w_next   = r_state;
        s_avalid = 1'b0;
        s_wvalid = 1'b0;
        s_rready = 1'b0;
        m_aready = '0;
        m_wready = '0;
        m_rvalid = '0;
        s_addr   = m_addr[r_grant];
        s_awrite = m_awrite[r_grant];
        s_wdata  = m_wdata[r_grant];
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = ADDR;
                end
            end
            ADDR: begin
                s_avalid = m_avalid[r_grant];
                m_aready = r_ownerMask & {N_MASTERS{s_aready}};
                if (m_avalid[r_grant] && s_aready) begin
                    w_next = m_awrite[r_grant] ? WDATA : RDATA;
                end
            end
            WDATA: begin
                s_wvalid = m_wvalid[r_grant];
                m_wready = r_ownerMask & {N_MASTERS{s_wready}};
                if (m_wvalid[r_grant] && s_wready) begin
                    w_next = IDLE;
                end
            end
            RDATA: begin
                s_rready = m_rready[r_grant];
                m_rvalid = r_ownerMask & {N_MASTERS{s_rvalid}};
                if (m_rready[r_grant] && s_rvalid) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign m_rdata   = s_rdata;
    assign grant_idx = r_grant;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Randomised scoreboard bench for axi_bus_arbiter plus a small fixed-priority
// instance exercised with continuous requests from masters 0 and 3.
module tb_axi_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam int M_IDLE = 0;
    localparam int M_ADDR = 1;
    localparam int M_WR   = 2;
    localparam int M_RD   = 3;

    typedef struct {
        int              master;
        logic [AW-1:0]   addr;
        logic            write;
        logic [DW-1:0]   wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N-1:0][AW-1:0] mAddr   = '0;
    logic [N-1:0]         mAvalid = '0;
    logic [N-1:0]         mAwrite = '0;
    logic [N-1:0]         mWvalid = '0;
    logic [N-1:0]         mRready = '0;
    logic [N-1:0][DW-1:0] mWdata  = '0;
    logic [N-1:0]         mAready;
    logic [N-1:0]         mWready;
    logic [N-1:0]         mRvalid;
    logic [DW-1:0]        mRdata;
    logic [AW-1:0]        sAddr;
    logic                 sAvalid;
    logic                 sAwrite;
    logic                 sWvalid;
    logic                 sRready;
    logic [DW-1:0]        sWdata;
    logic                 sAready = 1'b0;
    logic                 sWready = 1'b0;
    logic                 sRvalid = 1'b0;
    logic [DW-1:0]        sRdata  = '0;
    logic [1:0]           grantIdx;
    logic                 busy;

    logic                 fxRst     = 1'b1;
    logic [N-1:0][AW-1:0] fxMAddr   = '0;
    logic [N-1:0]         fxMAvalid = '0;
    logic [N-1:0]         fxMAwrite = '0;
    logic [N-1:0]         fxMWvalid = '0;
    logic [N-1:0]         fxMRready = '1;
    logic [N-1:0][DW-1:0] fxMWdata  = '0;
    logic [N-1:0]         fxMAready;
    logic [N-1:0]         fxMWready;
    logic [N-1:0]         fxMRvalid;
    logic [DW-1:0]        fxMRdata;
    logic [AW-1:0]        fxSAddr;
    logic                 fxSAvalid;
    logic                 fxSAwrite;
    logic                 fxSWvalid;
    logic                 fxSRready;
    logic [DW-1:0]        fxSWdata;
    logic [1:0]           fxGrantIdx;
    logic                 fxBusy;
    logic                 fxDone = 1'b0;

    int   total = 0;
    int   bad   = 0;
    int   popped = 0;

    int   mdlPhase = M_IDLE;
    int   mdlOwner = 0;
    int   mdlPtr   = 0;
    txn_t expQ[$];
    int   grantLog[$];
    txn_t cur;
    logic curValid = 1'b0;

    int   mst[N];
    int   reqPct   = 30;
    logic readOnly = 1'b0;
    logic holdW    = 1'b0;
    logic rstReq   = 1'b0;
    logic chkReset = 1'b0;
    logic monEn    = 1'b0;
    logic [N-1:0] capA;
    logic [N-1:0] capW;
    logic [N-1:0] capR;

    always #5 clk = ~clk;

    axi_bus_arbiter #(
        .N_MASTERS      (N),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .ARB_MODE       (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_addr    (mAddr),
        .m_avalid  (mAvalid),
        .m_awrite  (mAwrite),
        .m_wvalid  (mWvalid),
        .m_rready  (mRready),
        .m_wdata   (mWdata),
        .m_aready  (mAready),
        .m_wready  (mWready),
        .m_rvalid  (mRvalid),
        .m_rdata   (mRdata),
        .s_addr    (sAddr),
        .s_avalid  (sAvalid),
        .s_awrite  (sAwrite),
        .s_wvalid  (sWvalid),
        .s_rready  (sRready),
        .s_wdata   (sWdata),
        .s_aready  (sAready),
        .s_wready  (sWready),
        .s_rvalid  (sRvalid),
        .s_rdata   (sRdata),
        .grant_idx (grantIdx),
        .busy      (busy)
    );

    axi_bus_arbiter #(
        .N_MASTERS      (N),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .ARB_MODE       (1)
    ) fxDut (
        .clk       (clk),
        .rst       (fxRst),
        .m_addr    (fxMAddr),
        .m_avalid  (fxMAvalid),
        .m_awrite  (fxMAwrite),
        .m_wvalid  (fxMWvalid),
        .m_rready  (fxMRready),
        .m_wdata   (fxMWdata),
        .m_aready  (fxMAready),
        .m_wready  (fxMWready),
        .m_rvalid  (fxMRvalid),
        .m_rdata   (fxMRdata),
        .s_addr    (fxSAddr),
        .s_avalid  (fxSAvalid),
        .s_awrite  (fxSAwrite),
        .s_wvalid  (fxSWvalid),
        .s_rready  (fxSRready),
        .s_wdata   (fxSWdata),
        .s_aready  (1'b1),
        .s_wready  (1'b1),
        .s_rvalid  (1'b1),
        .s_rdata   (32'h0000_1234),
        .grant_idx (fxGrantIdx),
        .busy      (fxBusy)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] ownerMask(input int m);
        logic [N-1:0] r;
        r = '0;
        if (m >= 0 && m < N) r[m] = 1'b1;
        return r;
    endfunction

    function automatic int firstSet(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction-level reference: whoever is first at or after the pointer
    // gets the bus, and the bus is free again once its single beat is done.
    task automatic modelStep();
        int w;
        case (mdlPhase)
            M_IDLE: begin
                if (mAvalid != '0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && mAvalid[(mdlPtr + k) % N]) w = (mdlPtr + k) % N;
                    expQ.push_back('{master: w, addr: mAddr[w], write: mAwrite[w], wdata: mWdata[w]});
                    mdlOwner = w;
                    mdlPtr   = (w + 1) % N;
                    mdlPhase = M_ADDR;
                end
            end
            M_ADDR: if (mAvalid[mdlOwner] && sAready) mdlPhase = mAwrite[mdlOwner] ? M_WR : M_RD;
            M_WR:   if (mWvalid[mdlOwner] && sWready) mdlPhase = M_IDLE;
            default: if (mRready[mdlOwner] && sRvalid) mdlPhase = M_IDLE;
        endcase
    endtask

    task automatic masterStep();
        for (int i = 0; i < N; i++) begin
            case (mst[i])
                0: if (int'($urandom_range(99)) < reqPct) begin
                    mAddr[i]   = $urandom & 32'hFFFF_FFFC;
                    mAwrite[i] = readOnly ? 1'b0 : 1'($urandom_range(1));
                    mWdata[i]  = $urandom;
                    mAvalid[i] = 1'b1;
                    mst[i]     = 1;
                end
                1: if (capA[i]) begin
                    mAvalid[i] = 1'b0;
                    mst[i]     = mAwrite[i] ? 2 : 3;
                end
                2: if (mWvalid[i] && capW[i]) begin
                    mWvalid[i] = 1'b0;
                    mst[i]     = 0;
                end else if ($urandom_range(1) == 1) mWvalid[i] = 1'b1;
                default: if (mRready[i] && capR[i]) begin
                    mRready[i] = 1'b0;
                    mst[i]     = 0;
                end else if ($urandom_range(1) == 1) mRready[i] = 1'b1;
            endcase
        end
    endtask

    task automatic slaveStep();
        sAready = 1'($urandom_range(1));
        sWready = holdW ? 1'b0 : 1'($urandom_range(1));
        sRvalid = ($urandom_range(2) != 0);
        sRdata  = $urandom;
    endtask

    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            capA = mAready;
            capW = mWready;
            capR = mRvalid;
            if (chkReset) begin
                checkOutput("resetBusy", busy, 0);
                checkOutput("resetGrantIdx", grantIdx, 0);
                checkOutput("resetMasterOut", {mAready, mWready, mRvalid}, 0);
                checkOutput("resetSlaveOut", {sAvalid, sWvalid, sRready}, 0);
                chkReset = 1'b0;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                mdlPhase = M_IDLE;
                mdlOwner = 0;
                mdlPtr   = 0;
                expQ.delete();
                grantLog.delete();
                curValid = 1'b0;
                for (int i = 0; i < N; i++) mst[i] = 0;
                mAvalid  = '0;
                mWvalid  = '0;
                mRready  = '0;
                rst      = 1'b0;
                chkReset = 1'b1;
                monEn    = 1'b1;
            end else begin
                modelStep();
                masterStep();
                if (rstReq) begin
                    rst    = 1'b1;
                    rstReq = 1'b0;
                end
            end
            slaveStep();
        end
    endtask

    // Monitor: routing against the model every cycle, and scoreboard pops on
    // every address handshake the slave actually sees.
    always @(negedge clk) begin
        logic [N-1:0] expA, expW, expR;
        logic expSav, expSwv, expSrr;
        if (monEn) begin
            expA = '0; expW = '0; expR = '0;
            expSav = 1'b0; expSwv = 1'b0; expSrr = 1'b0;
            case (mdlPhase)
                M_ADDR: begin expSav = mAvalid[mdlOwner]; if (sAready) expA = ownerMask(mdlOwner); end
                M_WR:   begin expSwv = mWvalid[mdlOwner]; if (sWready) expW = ownerMask(mdlOwner); end
                M_RD:   begin expSrr = mRready[mdlOwner]; if (sRvalid) expR = ownerMask(mdlOwner); end
                default: ;
            endcase
            checkOutput("busy", busy, (mdlPhase != M_IDLE));
            checkOutput("grantIdx", grantIdx, mdlOwner);
            checkOutput("routeMaster", {mAready, mWready, mRvalid}, {expA, expW, expR});
            checkOutput("routeSlave", {sAvalid, sWvalid, sRready}, {expSav, expSwv, expSrr});
            if (sAvalid && sAready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL scoreEmpty actual=address handshake required=pending grant at %0t", $time);
                end else begin
                    cur      = expQ.pop_front();
                    curValid = 1'b1;
                    popped++;
                    checkOutput("addrValue", sAddr, cur.addr);
                    checkOutput("addrWrite", sAwrite, cur.write);
                    checkOutput("addrOwner", mAready, ownerMask(cur.master));
                    grantLog.push_back(firstSet(mAready));
                end
            end
            if (sWvalid && sWready) begin
                checkOutput("wBeatExpected", {curValid, cur.write}, 2'b11);
                checkOutput("wData", sWdata, cur.wdata);
                checkOutput("wOwner", mWready, ownerMask(cur.master));
                curValid = 1'b0;
            end
            if ((mRvalid & mRready) != '0) begin
                checkOutput("rBeatExpected", {curValid, cur.write}, 2'b10);
                checkOutput("rData", mRdata, sRdata);
                checkOutput("rOwner", mRvalid & mRready, ownerMask(cur.master));
                curValid = 1'b0;
            end
        end
    end

    // Fixed-priority instance: m0 and m3 request continuously, slave always
    // ready, so m0 wins every 3-cycle slot until it stops asking.
    initial begin
        int m0Grants;
        logic m3Seen;
        m0Grants = 0;
        m3Seen   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fxRst     = 1'b0;
        fxMAvalid = 4'b1001;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            checkOutput("fixedOthersIdle", fxMAready & 4'b1110, 0);
            checkOutput("fixedGrantIdx", fxGrantIdx, 0);
            if (fxMAready[0]) m0Grants++;
        end
        fxMAvalid = 4'b1000;
        checkOutput("fixedM0Grants", m0Grants, 10);
        for (int j = 0; j < 8 && !m3Seen; j++) begin
            @(negedge clk);
            if (fxMAready[3]) m3Seen = 1'b1;
        end
        checkOutput("fixedM3AfterM0", m3Seen, 1);
        fxDone = 1'b1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fairExp[6];
        fairExp = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < N; i++) mst[i] = 0;
        $display("[TB] random traffic");
        applyStimulus(1500);

        $display("[TB] reset during stalled write beat");
        holdW = 1'b1;
        for (int i = 0; i < 300 && mdlPhase != M_WR; i++) applyStimulus(1);
        if (mdlPhase != M_WR) begin
            total++;
            bad++;
            $display("[TB] FAIL reachWdata actual=phase %0d required=write phase", mdlPhase);
        end
        rstReq   = 1'b1;
        reqPct   = 100;
        readOnly = 1'b1;
        applyStimulus(2);
        holdW = 1'b0;

        $display("[TB] round-robin fairness after reset");
        applyStimulus(150);
        checkOutput("fairCount", grantLog.size() >= 6, 1);
        for (int k = 0; k < 6; k++)
            if (k < grantLog.size()) checkOutput($sformatf("fairOrder%0d", k), grantLog[k], fairExp[k]);

        $display("[TB] random traffic again");
        reqPct   = 30;
        readOnly = 1'b0;
        applyStimulus(500);

        checkOutput("scoreboardActivity", popped >= 100, 1);
        checkOutput("fixedDone", fxDone, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_bus_arbiter.md
# axi_bus_arbiter

- Parametrised N-master to 1-slave arbiter for the packet switch's simplified AXI bus (single ADDR/AVALID/AREADY/AWRITE address channel, single-beat W and R channels).
- Serialises whole transactions (address phase plus one data beat) from `N_MASTERS` requesters onto one slave port.
- Arbitration is round-robin or fixed-priority, selected by parameter.
- Sits between the switch's port engines and the shared buffer/register slave.

## Interface
- `N_MASTERS`, default 4: number of master ports, 2..16.
- `AXI_ADDR_WIDTH`, default 32: address width.
- `AXI_DATA_WIDTH`, default 32: data width.
- `ARB_MODE`, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `clk`  in  1: sole clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `m_addr`  in  [N_MASTERS][AXI_ADDR_WIDTH]: per-master ADDR.
- `m_avalid`, `m_awrite`, `m_wvalid`, `m_rready`  in  [N_MASTERS]: per-master handshake inputs.
- `m_wdata`  in  [N_MASTERS][AXI_DATA_WIDTH]: per-master WDATA.
- `m_aready`, `m_wready`, `m_rvalid`  out  [N_MASTERS]: per-master handshake outputs.
- `m_rdata`  out  AXI_DATA_WIDTH: slave RDATA, broadcast to all masters; qualified by the `m_rvalid` bit.
- `s_addr`  out  AXI_ADDR_WIDTH, `s_avalid`, `s_awrite`, `s_wvalid`, `s_rready`  out  1, `s_wdata`  out  AXI_DATA_WIDTH: slave-side Master outputs.
- `s_aready`, `s_wready`, `s_rvalid`  in  1, `s_rdata`  in  AXI_DATA_WIDTH: slave-side inputs.
- `grant_idx`  out  $clog2(N_MASTERS): current or last owner, for debug.
- `busy`  out  1: high in any state except IDLE.

## Operation
- A transaction is:
  - one address handshake (AVALID & AREADY, with AWRITE sampled at that handshake), then
  - exactly one W beat (write) or one R beat (read).
- Each master holds AVALID, ADDR and AWRITE stable until AREADY.
- FSM states:
  - IDLE: no owner. If any `m_avalid` is high, arbitrate, register the winner in `grant_idx`, go to ADDR.
  - ADDR: forward the owner's ADDR/AVALID/AWRITE to the slave and route `s_aready` to the owner's `m_aready`. On handshake go to WDATA if AWRITE=1, else RDATA.
  - WDATA: forward the owner's WVALID/WDATA and route `s_wready` back. On handshake go to IDLE.
  - RDATA: forward `s_rvalid` to the owner and route the owner's RREADY to `s_rready`. On handshake go to IDLE.
- Non-owners see `m_aready`=0, `m_wready`=0 and `m_rvalid`=0 at all times.
- Slave outputs not used by the current state are forced to 0: `s_avalid` outside ADDR, `s_wvalid` outside WDATA, `s_rready` outside RDATA. `s_addr`/`s_wdata` are don't-care while their valid is low; drive them from the owner's mux.
- Round-robin:
  - Priority pointer `ptr` names the highest-priority index.
  - The winner is the first requester at or after `ptr`, wrapping modulo N_MASTERS.
  - On grant, `ptr` becomes winner+1, wrapping from N_MASTERS-1 to 0.
- Fixed priority: lowest requesting index wins; `ptr` is unused.
- A master that drops AVALID while waiting in IDLE simply loses its request. No requests are queued.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant_idx`=0, `busy`=0, every `m_aready`/`m_wready`/`m_rvalid`=0, `s_avalid`/`s_wvalid`/`s_rready`=0.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge k gives `s_avalid`=1 after edge k (i.e. in cycle k+1).
- All slave-to-master ready/valid routing within a state is combinational, with zero added latency.
- Minimum transaction length is 3 cycles: IDLE, ADDR and data phase, each with an immediate handshake. Back-to-back transactions have a 1-cycle IDLE bubble.
- Simultaneous requests are resolved in the same IDLE cycle. A new request during non-IDLE states waits.
- `rst` asserted mid-transaction:
  - next edge forces IDLE and all reset values;
  - the in-flight slave beat is abandoned;
  - the slave must tolerate this.
- The slave may stall indefinitely. There is no timeout; the state is held.

## Structure
- `axi_bus_pkg`: `arb_state_t` enum (IDLE, ADDR, WDATA, RDATA) and `arb_mode_e` (ARB_RR=0, ARB_FIXED=1).
- Sub-module `rr_pick`:
  - combinational: request vector + `ptr` -> one-hot winner + index + `any`;
  - parametrised on N; reused for fixed mode with `ptr` tied to 0.
- FSM, `ptr` register and the muxes stay in `axi_bus_arbiter`.

## Test plan
- Single write: after reset, m1 sends addr 0x100 with AWRITE=1 and WDATA 0xDEADBEEF; the slave answers ready immediately. Expect `s_avalid` in cycle 1 with `s_addr`=0x100, W handshake in cycle 2, `busy` low in cycle 3, and `m_aready`/`m_wready` pulse only on bit 1.
- Read with stall: m2 reads 0x40 and the slave holds `s_rvalid` low for 5 cycles, then returns 0x1234. Expect state held in RDATA, `m_rvalid[2]` high exactly on the beat, and `m_rdata`=0x1234.
- Round-robin fairness: N=4 with all masters requesting reads continuously. Expect grant order 0,1,2,3,0,1; no master is granted twice before every other requester.
- Fixed mode: ARB_MODE=1 with m0 and m3 requesting continuously. Expect m0 to win every grant and m3 never to be granted while m0 requests.
- Reset mid-write: assert `rst` during WDATA with `s_wready`=0. Expect IDLE next cycle, all outputs at reset values and `ptr`=0, then a clean grant of the lowest requester.
- Non-owner isolation: while m0 is in RDATA, m1 raises AVALID. Expect `m_aready[1]`=0 until m0 completes, then m1 granted after the 1-cycle IDLE bubble.
